// File: rtl/regfile_bus_ctrl.sv
// Initiator for the general-purpose register file's single-select port.
// Takes LDI / MOV / RD commands over a valid/ready handshake and sequences
// the port's write/output enables, select and write data. RD results are
// returned over a valid/ready response channel. Every rf_* and rsp_* output
// comes straight from a flop. Each flop is loaded with the value that the
// next state requires.
module regfile_bus_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rs,
    input  logic [N-1:0]     cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             rf_write_en,
    output logic             rf_out_en,
    output logic [2:0]       rf_sel,
    output logic [N-1:0]     rf_wdata,
    input  logic [N-1:0]     rf_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    // The source index and the immediate go straight into the registered
    // rf_sel / rf_wdata drivers on the accept edge. Only the opcode and the
    // destination index must persist beyond that edge.
    logic [1:0]       op_reg, op_next;
    logic [2:0]       rd_reg, rd_next;
    logic [N-1:0]     data_reg, data_next;
    logic             rf_write_en_reg, rf_write_en_next;
    logic             rf_out_en_reg, rf_out_en_next;
    logic [2:0]       rf_sel_reg, rf_sel_next;
    logic [N-1:0]     rf_wdata_reg, rf_wdata_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [N-1:0]     rsp_data_reg, rsp_data_next;
    logic [CNT_W-1:0] wr_count_reg, wr_count_next;

    assign cmd_ready   = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign rf_write_en = rf_write_en_reg;
    assign rf_out_en   = rf_out_en_reg;
    assign rf_sel      = rf_sel_reg;
    assign rf_wdata    = rf_wdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign wr_count    = wr_count_reg;

    // Next-state logic and the port drive values that the next state requires.
    always_comb begin
        state_next       = state_reg;
        op_next          = op_reg;
        rd_next          = rd_reg;
        data_next        = data_reg;
        rf_write_en_next = 1'b0;
        rf_out_en_next   = 1'b0;
        rf_sel_next      = rf_sel_reg;
        rf_wdata_next    = '0;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        wr_count_next    = wr_count_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    op_next = cmd_op;
                    rd_next = cmd_rd;
                    case (cmd_op)
                        OP_LDI: begin
                            state_next       = WRITE;
                            rf_write_en_next = 1'b1;
                            rf_sel_next      = cmd_rd;
                            rf_wdata_next    = cmd_imm;
                        end
                        OP_MOV, OP_RD: begin
                            state_next     = READ;
                            rf_out_en_next = 1'b1;
                            rf_sel_next    = cmd_rs;
                        end
                        default: begin
                            // NOP: accepted; nothing else happens.
                        end
                    endcase
                end
            end
            READ: begin
                // rf_rdata is valid during this cycle. It is captured at the closing edge.
                data_next = rf_rdata;
                if (op_reg == OP_MOV) begin
                    state_next       = WRITE;
                    rf_write_en_next = 1'b1;
                    rf_sel_next      = rd_reg;
                    rf_wdata_next    = rf_rdata;
                end else begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = rf_rdata;
                end
            end
            WRITE: begin
                wr_count_next = wr_count_reg + CNT_ONE;
                state_next    = IDLE;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched command and registered port drivers.
    // Reset abandons any sequence that is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            op_reg          <= OP_NOP;
            rd_reg          <= '0;
            data_reg        <= '0;
            rf_write_en_reg <= 1'b0;
            rf_out_en_reg   <= 1'b0;
            rf_sel_reg      <= '0;
            rf_wdata_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            wr_count_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            op_reg          <= op_next;
            rd_reg          <= rd_next;
            data_reg        <= data_next;
            rf_write_en_reg <= rf_write_en_next;
            rf_out_en_reg   <= rf_out_en_next;
            rf_sel_reg      <= rf_sel_next;
            rf_wdata_reg    <= rf_wdata_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            wr_count_reg    <= wr_count_next;
        end
    end

endmodule

// File: tb/tb_regfile_bus_ctrl.sv
// Bench for regfile_bus_ctrl. The bench contains a simple 8-entry register file.
// It applies directed cycle-level steps and then random command traffic.
// The random traffic is checked against an architectural model made of a
// register array and a write counter.
module tb_regfile_bus_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [2:0]       cmd_rd;
    logic [2:0]       cmd_rs;
    logic [N-1:0]     cmd_imm;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_data;
    logic             rf_write_en;
    logic             rf_out_en;
    logic [2:0]       rf_sel;
    logic [N-1:0]     rf_wdata;
    logic [N-1:0]     rf_rdata;
    logic             busy;
    logic [CNT_W-1:0] wr_count;

    regfile_bus_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rf_write_en(rf_write_en), .rf_out_en(rf_out_en), .rf_sel(rf_sel),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .busy(busy), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model. The read bus carries junk while the output is not enabled.
    logic [N-1:0] rf_mem [8];
    logic         mem_clr;
    assign rf_rdata = rf_out_en ? rf_mem[rf_sel] : 8'hEE;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
        end else if (rf_write_en) begin
            rf_mem[rf_sel] <= rf_wdata;
        end
    end

    int           tests;
    int           fails;
    logic [N-1:0] ref_regs [8];
    int           ref_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and check the port invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("en_exclusive", {31'b0, rf_out_en & rf_write_en}, 32'd0);
        if (!rf_write_en) chk("wdata_idle", {24'b0, rf_wdata}, 32'd0);
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [N-1:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_imm   = imm;
    endtask

    // Issue one command and run it to completion. The response side stalls at random.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [N-1:0] imm);
        logic [N-1:0] exp_rsp;
        logic         got;
        int           n;
        chk("ready_before_cmd", {31'b0, cmd_ready}, 32'd1);
        drive(op, rd, rs, imm);
        exp_rsp = ref_regs[rs];
        if (op == 2'b01) begin
            ref_regs[rd] = imm;
            ref_cnt = (ref_cnt + 1) % (1 << CNT_W);
        end else if (op == 2'b10) begin
            ref_regs[rd] = ref_regs[rs];
            ref_cnt = (ref_cnt + 1) % (1 << CNT_W);
        end
        tick();
        cmd_valid = 1'b0;
        got = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            rsp_ready = 1'($urandom % 2);
            if (rsp_valid) chk("rsp_data", {24'b0, rsp_data}, {24'b0, exp_rsp});
            if (rsp_valid && rsp_ready) got = 1'b1;
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        chk("cmd_done", {31'b0, cmd_ready}, 32'd1);
        if (op == 2'b11) chk("rsp_seen", {31'b0, got}, 32'd1);
        chk("wr_count", {28'b0, wr_count}, 32'(ref_cnt));
        $display("[TB] cmd op=%0d rd=%0d rs=%0d imm=%02h cycles=%0d wr_count=%0d",
                 op, rd, rs, imm, n + 1, wr_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        ref_cnt = 0;
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        mem_clr = 1'b1;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_rd = '0;
        cmd_rs = '0;
        cmd_imm = '0;
        rsp_ready = 1'b0;

        // Reset is held for two cycles.
        tick();
        tick();
        chk("rst_write_en", {31'b0, rf_write_en}, 32'd0);
        chk("rst_out_en", {31'b0, rf_out_en}, 32'd0);
        chk("rst_sel", {29'b0, rf_sel}, 32'd0);
        chk("rst_wdata", {24'b0, rf_wdata}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
        chk("rst_wr_count", {28'b0, wr_count}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        mem_clr = 1'b0;
        tick();
        chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
        $display("[TB] reset released");

        // Issue LDI r3 = A5.
        drive(2'b01, 3'd3, 3'd0, 8'hA5);
        tick();
        cmd_valid = 1'b0;
        chk("ldi_we", {31'b0, rf_write_en}, 32'd1);
        chk("ldi_sel", {29'b0, rf_sel}, 32'd3);
        chk("ldi_wdata", {24'b0, rf_wdata}, 32'hA5);
        chk("ldi_ready_t1", {31'b0, cmd_ready}, 32'd0);
        tick();
        chk("ldi_ready_t2", {31'b0, cmd_ready}, 32'd1);
        chk("ldi_count", {28'b0, wr_count}, 32'd1);
        chk("ldi_sel_hold", {29'b0, rf_sel}, 32'd3);
        ref_regs[3] = 8'hA5;
        ref_cnt = 1;
        $display("[TB] LDI r3=A5 wr_count=%0d", wr_count);

        // Issue LDI r2 = 3C, then MOV r5 <- r2.
        run_cmd(2'b01, 3'd2, 3'd0, 8'h3C);
        drive(2'b10, 3'd5, 3'd2, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("mov_oe", {31'b0, rf_out_en}, 32'd1);
        chk("mov_rd_sel", {29'b0, rf_sel}, 32'd2);
        tick();
        chk("mov_we", {31'b0, rf_write_en}, 32'd1);
        chk("mov_wr_sel", {29'b0, rf_sel}, 32'd5);
        chk("mov_wdata", {24'b0, rf_wdata}, 32'h3C);
        tick();
        chk("mov_ready_t3", {31'b0, cmd_ready}, 32'd1);
        chk("mov_r5", {24'b0, rf_mem[5]}, 32'h3C);
        ref_regs[5] = 8'h3C;
        ref_cnt = 3;
        $display("[TB] MOV r5<-r2 r5=%02h", rf_mem[5]);

        // Issue RD r2 while the response side stalls for four cycles.
        drive(2'b11, 3'd0, 3'd2, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("rd_oe", {31'b0, rf_out_en}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rd_stall_data", {24'b0, rsp_data}, 32'h3C);
            chk("rd_stall_ready", {31'b0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_done_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rd_done_ready", {31'b0, cmd_ready}, 32'd1);
        $display("[TB] RD r2 stalled 4 cycles data=3C");

        // Hold cmd_valid through a MOV. The second command must wait until T+3.
        drive(2'b10, 3'd6, 3'd3, 8'h00);
        tick();
        chk("held_t1_ready", {31'b0, cmd_ready}, 32'd0);
        chk("held_t1_sel", {29'b0, rf_sel}, 32'd3);
        drive(2'b01, 3'd7, 3'd0, 8'h5A);
        tick();
        chk("held_t2_we", {31'b0, rf_write_en}, 32'd1);
        chk("held_t2_sel", {29'b0, rf_sel}, 32'd6);
        chk("held_t2_wdata", {24'b0, rf_wdata}, 32'hA5);
        chk("held_t2_ready", {31'b0, cmd_ready}, 32'd0);
        tick();
        chk("held_t3_ready", {31'b0, cmd_ready}, 32'd1);
        chk("held_t3_we", {31'b0, rf_write_en}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("held_t4_we", {31'b0, rf_write_en}, 32'd1);
        chk("held_t4_sel", {29'b0, rf_sel}, 32'd7);
        chk("held_t4_wdata", {24'b0, rf_wdata}, 32'h5A);
        tick();
        ref_regs[6] = 8'hA5;
        ref_regs[7] = 8'h5A;
        ref_cnt = 5;
        chk("held_count", {28'b0, wr_count}, 32'(ref_cnt));
        $display("[TB] held-valid MOV then LDI wr_count=%0d", wr_count);

        // A NOP causes no port activity.
        drive(2'b00, 3'd1, 3'd1, 8'hFF);
        tick();
        cmd_valid = 1'b0;
        chk("nop_ready", {31'b0, cmd_ready}, 32'd1);
        chk("nop_we", {31'b0, rf_write_en}, 32'd0);
        chk("nop_oe", {31'b0, rf_out_en}, 32'd0);
        chk("nop_count", {28'b0, wr_count}, 32'(ref_cnt));
        $display("[TB] NOP");

        // Assert reset while an RD response is pending. The response is dropped.
        drive(2'b11, 3'd0, 3'd7, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rdrst_pending", {31'b0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rdrst_dropped", {31'b0, rsp_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rdrst_after", {31'b0, rsp_valid}, 32'd0);
        chk("rdrst_ready", {31'b0, cmd_ready}, 32'd1);
        ref_cnt = 0;
        $display("[TB] reset during RD response");

        // Issue LDI r3 = A5 so that wr_count is nonzero.
        // Then assert reset during the READ phase of a MOV.
        run_cmd(2'b01, 3'd3, 3'd0, 8'hA5);
        drive(2'b10, 3'd4, 3'd3, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("movrst_oe", {31'b0, rf_out_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("movrst_oe_clr", {31'b0, rf_out_en}, 32'd0);
        chk("movrst_count", {28'b0, wr_count}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("movrst_no_write", {31'b0, rf_write_en}, 32'd0);
        end
        chk("movrst_r4", {24'b0, rf_mem[4]}, {24'b0, ref_regs[4]});
        chk("movrst_count2", {28'b0, wr_count}, 32'd0);
        ref_cnt = 0;
        $display("[TB] reset during MOV read");

        // Issue 2^CNT_W LDIs. wr_count must pass 15 and wrap to 0.
        for (int i = 0; i < 16; i++) begin
            run_cmd(2'b01, 3'($urandom_range(0, 7)), 3'd0, 8'($urandom));
            if (i == 14) chk("wrap_max", {28'b0, wr_count}, 32'd15);
        end
        chk("wrap_zero", {28'b0, wr_count}, 32'd0);

        // Run random traffic against the architectural model.
        for (int i = 0; i < 60; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 8'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            chk("final_reg", {24'b0, rf_mem[i]}, {24'b0, ref_regs[i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
